// File: rtl/mp_intc_pkg.sv
// mp_intc_pkg: shared constants and types for the mp_intc interrupt controller.
// Holds the register byte offsets, the management FSM state encoding, the
// interrupt code width and the latched management request payload.
package mp_intc_pkg;

    localparam int unsigned CODE_W = 5;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned OFF_W  = 5;

    // Register byte offsets inside the 32-byte window
    localparam logic [OFF_W-1:0] INTC_PEND  = 5'h00;
    localparam logic [OFF_W-1:0] INTC_MASK  = 5'h04;
    localparam logic [OFF_W-1:0] INTC_CLR   = 5'h08;
    localparam logic [OFF_W-1:0] INTC_TRIG  = 5'h0C;
    localparam logic [OFF_W-1:0] INTC_CLAIM = 5'h10;
    localparam logic [OFF_W-1:0] INTC_SWSET = 5'h14;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK  = 2'd1,
        ST_RXE  = 2'd2
    } state_t;

    // Management request captured when it is accepted in IDLE
    typedef struct packed {
        logic [OFF_W-1:0]  off;
        logic              rwn;
        logic [1:0]        wen;
        logic [DATA_W-1:0] txd;
    } mgmt_req_t;

endpackage

// File: rtl/mp_intc_prio.sv
// intc_prio: combinational lowest-index priority encoder.
// Ports: req (NSRC request bits) -> valid_c (any set), idx_c (lowest set index,
// 0 when none).
module intc_prio
    import mp_intc_pkg::*;
#(
    parameter int unsigned NSRC = 16
) (
    input  logic [NSRC-1:0]   req,
    output logic              valid_c,
    output logic [CODE_W-1:0] idx_c
);

    // Scan from the top down so the lowest set index is the last assignment
    always_comb begin
        valid_c = |req;
        idx_c   = '0;
        for (int i = int'(NSRC) - 1; i >= 0; i--) begin
            if (req[i]) idx_c = CODE_W'(i);
        end
    end

endmodule

// File: rtl/mp_intc.sv
// mp_intc: interrupt controller feeding the branch/PC unit.
// Latches NSRC interrupt lines into pending state, masks them, and presents the
// lowest-index active source as exi/exi_code. Registers live in a 32-byte
// window at BASE_ADR on the management bus.
// Ports: sys_clk, sys_rst (sync, active-high), irq_src[NSRC];
//        mgmt_req/adr/rwn/wen/txd in, mgmt_ack/rxe/rxd out; exi, exi_code out.
// Build option: define MP_INTC_EDGE_EN to build the TRIG register and edge
// detectors; otherwise all sources are level and TRIG reads 0.
module mp_intc
    import mp_intc_pkg::*;
#(
    parameter int unsigned NSRC     = 16,
    parameter logic [12:0] BASE_ADR = 13'h0100
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic [NSRC-1:0]   irq_src,
    input  logic              mgmt_req,
    input  logic [31:0]       mgmt_adr,
    input  logic              mgmt_rwn,
    input  logic [1:0]        mgmt_wen,
    input  logic [31:0]       mgmt_txd,
    output logic              mgmt_ack,
    output logic              mgmt_rxe,
    output logic [31:0]       mgmt_rxd,
    output logic              exi,
    output logic [CODE_W-1:0] exi_code
);

    state_t            state_q, state_nxt;
    mgmt_req_t         req_q;
    logic              accept_c, ack_nxt, rxe_nxt;
    logic              wr_c, rd_c;
    logic [NSRC-1:0]   src_q, mask_q, sticky_q;
    logic [NSRC-1:0]   trig_c, edge_c, pend_c, wmask_c, wdat_c, clr_c, swset_c;
    logic              prio_valid_c;
    logic [CODE_W-1:0] prio_idx_c;
    logic [31:0]       rd_mux_c;
    logic              unused_c;

    // Address bits outside [12:5]/[4:0] and txd bits above NSRC are don't-care
    assign unused_c = ^{mgmt_adr, req_q};

    // Management FSM: next state and registered pulse outputs
    always_comb begin
        state_nxt = state_q;
        ack_nxt   = 1'b0;
        rxe_nxt   = 1'b0;
        accept_c  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (mgmt_req && (mgmt_adr[12:5] == BASE_ADR[12:5])) begin
                    accept_c  = 1'b1;
                    ack_nxt   = 1'b1;
                    state_nxt = ST_ACK;
                end
            end
            ST_ACK: begin
                if (req_q.rwn) begin
                    rxe_nxt   = 1'b1;
                    state_nxt = ST_RXE;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_RXE:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // FSM state, request latch and handshake pulses
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q  <= ST_IDLE;
            req_q    <= '0;
            mgmt_ack <= 1'b0;
            mgmt_rxe <= 1'b0;
        end else begin
            state_q  <= state_nxt;
            mgmt_ack <= ack_nxt;
            mgmt_rxe <= rxe_nxt;
            if (accept_c) begin
                req_q.off <= mgmt_adr[OFF_W-1:0];
                req_q.rwn <= mgmt_rwn;
                req_q.wen <= mgmt_wen;
                req_q.txd <= mgmt_txd;
            end
        end
    end

    // Register access happens at the edge that ends ACK
    assign wr_c = (state_q == ST_ACK) && !req_q.rwn;
    assign rd_c = (state_q == ST_ACK) &&  req_q.rwn;

    // Halfword write enables spread across the source bits
    always_comb begin
        wmask_c = '0;
        for (int i = 0; i < int'(NSRC); i++) begin
            wmask_c[i] = (i < 16) ? req_q.wen[0] : req_q.wen[1];
        end
    end

    assign wdat_c  = req_q.txd[NSRC-1:0] & wmask_c;
    assign clr_c   = (wr_c && (req_q.off == INTC_CLR))   ? wdat_c : '0;
    assign swset_c = (wr_c && (req_q.off == INTC_SWSET)) ? wdat_c : '0;

`ifdef MP_INTC_EDGE_EN
    logic [NSRC-1:0] trig_q;

    // Trigger mode register: 1 = edge, 0 = level
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            trig_q <= '0;
        end else if (wr_c && (req_q.off == INTC_TRIG)) begin
            trig_q <= (trig_q & ~wmask_c) | wdat_c;
        end
    end

    assign trig_c = trig_q;
    assign edge_c = irq_src & ~src_q & trig_q;
`else
    assign trig_c = '0;
    assign edge_c = '0;
`endif

    // Source history, mask and sticky pending; a set beats a same-cycle clear
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            src_q    <= '0;
            mask_q   <= '0;
            sticky_q <= '0;
        end else begin
            src_q    <= irq_src;
            sticky_q <= (sticky_q & ~clr_c) | swset_c | edge_c;
            if (wr_c && (req_q.off == INTC_MASK)) begin
                mask_q <= (mask_q & ~wmask_c) | wdat_c;
            end
        end
    end

    // Level sources contribute directly and are unaffected by CLR
    assign pend_c = sticky_q | (src_q & ~trig_c);

    intc_prio #(
        .NSRC (NSRC)
    ) u_prio (
        .req     (pend_c & mask_q),
        .valid_c (prio_valid_c),
        .idx_c   (prio_idx_c)
    );

    // Read mux; write-only and unmapped offsets read as 0
    always_comb begin
        rd_mux_c = '0;
        case (req_q.off)
            INTC_PEND:  rd_mux_c = 32'(pend_c);
            INTC_MASK:  rd_mux_c = 32'(mask_q);
            INTC_TRIG:  rd_mux_c = 32'(trig_c);
            INTC_CLAIM: rd_mux_c = 32'({exi, exi_code});
            default:    rd_mux_c = '0;
        endcase
    end

    // Interrupt output and held read data
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            exi      <= 1'b0;
            exi_code <= '0;
            mgmt_rxd <= '0;
        end else begin
            exi      <= prio_valid_c;
            exi_code <= prio_idx_c;
            if (rd_c) mgmt_rxd <= rd_mux_c;
        end
    end

endmodule

// File: doc/mp_intc.md
# mp_intc

Interrupt controller directly upstream of the branch/PC unit. It gathers up to `NSRC` peripheral interrupt lines and latches them into pending state. It masks them and priority-encodes them into the single `exi` / `exi_code` pair that the branch unit turns into a vectored trap. Software reaches its registers as a target on the management bus driven by the system-bus unit.

## Interface
Parameters:
- `NSRC`, 16: number of interrupt sources, 1..32.
- `BASE_ADR`, 13'h0100: byte base of a 32-byte register window; bits [4:0] must be 0.

Ports:
- `sys_clk`  in  1  single clock.
- `sys_rst`  in  1  reset; synchronous, active-high.
- `irq_src`  in  NSRC  interrupt lines, already synchronous to `sys_clk`.
- `mgmt_req`  in  1  request; held high until `mgmt_ack` is seen.
- `mgmt_adr`  in  32  byte address; only [12:0] are decoded.
- `mgmt_rwn`  in  1  1 = read, 0 = write.
- `mgmt_wen`  in  2  halfword write enables; [1] = bits 31:16, [0] = bits 15:0.
- `mgmt_txd`  in  32  write data.
- `mgmt_ack`  out  1  one-cycle accept pulse.
- `mgmt_rxe`  out  1  one-cycle read-data-valid pulse.
- `mgmt_rxd`  out  32  read data; held until the next read.
- `exi`  out  1  external interrupt request, level.
- `exi_code`  out  5  index of the winning source.

## Operation
Register map, byte offsets from `BASE_ADR`, 32-bit, with bits ≥ `NSRC` reading as 0:
- 0x00 PEND, RO: effective pending.
- 0x04 MASK, RW: per-source enable.
- 0x08 CLR, W1C: clears sticky pending bits.
- 0x0C TRIG, RW: 1 = edge, 0 = level.
- 0x10 CLAIM, RO: {26'b0, `exi`, `exi_code`}.
- 0x14 SWSET, W1S: sets sticky pending bits. Reads as 0.

Pending logic:
- `src_q` registers `irq_src` every cycle.
- Sticky bit is set by a rising edge (`irq_src & ~src_q & TRIG`) or by a SWSET write. It is cleared only by a CLR write.
- If set and clear hit the same bit in the same cycle, set wins.
- Effective `pend = sticky | (src_q & ~TRIG)`. A level source stays pending while its line is high; CLR does not affect that level contribution.

Priority:
- Source `active = pend & MASK`. The lowest set index wins.
- Registered each cycle: `exi` = |active, `exi_code` = winning index, or 0 if none.

Management FSM, states IDLE / ACK / RXE:
- IDLE: on `mgmt_req` with `mgmt_adr[12:5] == BASE_ADR[12:5]`, latch offset, `rwn`, `wen` and `txd`, then go to ACK. Out-of-window requests are ignored and the FSM stays in IDLE.
- ACK: `mgmt_ack` = 1 for one cycle.
  - Write: the register updates at the edge that ends ACK, with each halfword gated by `wen`. Then go to IDLE.
  - Read: go to RXE.
- RXE: `mgmt_rxe` = 1; `mgmt_rxd` carries the register value sampled at the end of ACK. Then go to IDLE.
- Unmapped offsets inside the window: the access is acknowledged, reads return 0, writes are ignored.
- `mgmt_req` is ignored outside IDLE.

## Timing
- Reset values: `mgmt_ack`=0, `mgmt_rxe`=0, `mgmt_rxd`=0, `exi`=0, `exi_code`=0. MASK, TRIG, sticky and `src_q` are 0. FSM = IDLE.
- Reset mid-transaction aborts it; no ack or rxe is issued afterwards.
- `irq_src` rising at edge k makes `exi` high after edge k+2: `src_q` updates at k+1 and `exi` at k+2.
- A MASK or CLR write at the end of ACK (edge a) changes `exi` after edge a+1.
- Write latency: ack 1 cycle after `req` is sampled.
- Read latency: ack 1 cycle after `req` is sampled, then `rxe` the next cycle.
- Back-to-back accesses: a new request is accepted at the first IDLE cycle.

## Configuration
- `MP_INTC_EDGE_EN` defined: TRIG register and edge detectors are built as described above.
- `MP_INTC_EDGE_EN` undefined: all sources are level. TRIG reads 0 and ignores writes. Sticky bits are set only by SWSET.

## Structure
- Shared package/defines hold:
  - the register offsets (`INTC_PEND`, `INTC_MASK`, `INTC_CLR`, `INTC_TRIG`, `INTC_CLAIM`, `INTC_SWSET`);
  - the FSM state encoding;
  - the 5-bit code width.
- One sub-module, `intc_prio`: combinational lowest-index priority encoder, `NSRC` → {valid, 5-bit index}.

## Test plan
- After reset, read MASK → rxd 0. `exi` stays 0 while all `irq_src` are high.
- Write MASK = 0x0000_0028 with wen=11 → ack after 1 cycle. Raise sources 3 and 5 (level) → `exi`=1, `exi_code`=3. Drop source 3 → `exi_code`=5 two cycles later.
- Set TRIG = 0x1 and MASK = 0x1, pulse `irq_src[0]` for one cycle → PEND reads 0x1 and `exi` stays 1. Write CLR = 0x1 → `exi` low after 2 cycles.
- Write CLR for bit 0 while `irq_src[0]` edges in the same cycle (edge mode) → PEND[0] stays 1.
- Write MASK with wen=01 and txd=0xFFFF_FFFF (NSRC=32) → MASK reads 0x0000_FFFF.
- Write to `BASE_ADR` + 0x40 → no ack within 10 cycles. SWSET = 0x4 with MASK bit 2 set → CLAIM reads 0x22.
